// File: rtl/o_serializer.sv
// o_serializer: parallel-to-serial converter with a one-word holding register.
// Words are accepted into the holding register and moved into the shift
// register, with no idle bit between consecutive words. Q is registered.
module o_serializer #(
    parameter int    WIDTH      = 8,
    parameter string BIT_ORDER  = "LSB_FIRST",
    parameter logic  IDLE_LEVEL = 1'b0
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             DATA_VALID,
    output logic             DATA_READY,
    output logic             Q,
    output logic             OE_OUT,
    output logic             TX_DONE
);

    generate
        if (WIDTH < 2 || WIDTH > 16 ||
            (BIT_ORDER != "LSB_FIRST" && BIT_ORDER != "MSB_FIRST")) begin : g_bad_param
            $fatal(1, "%m: illegal parameters WIDTH=%0d BIT_ORDER=%s; legal WIDTH is 2..16, legal BIT_ORDER is \"LSB_FIRST\" or \"MSB_FIRST\"",
                   WIDTH, BIT_ORDER);
        end
    endgenerate

    localparam bit              MSB_ORDER = (BIT_ORDER == "MSB_FIRST");
    localparam int              CNT_W     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   hr;
    logic               hr_full;
    logic [WIDTH-1:0]   sr;
    logic [CNT_W-1:0]   cnt;
    logic               accept;

    // Bit that goes on the line first from a word
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_ORDER ? w[WIDTH-1] : w[0];
    endfunction

    // Word with the bit just sent removed, so the next one sits in first_bit position
    function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] w);
        return MSB_ORDER ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Ready comes straight from the registered flag, never from DATA_VALID
    assign DATA_READY = !hr_full;
    assign accept     = DATA_VALID && !hr_full;

    // Holding-register data is only read while hr_full is set, so it carries no reset
    always_ff @(posedge CLK_IN) begin
        if (accept) begin
            hr <= D;
        end
    end

    // Control FSM, shift register and registered line outputs
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            hr_full <= 1'b0;
            cnt     <= '0;
            sr      <= '0;
            Q       <= IDLE_LEVEL;
            OE_OUT  <= 1'b0;
            TX_DONE <= 1'b0;
        end else begin
            TX_DONE <= 1'b0;
            // Acceptance needs hr_full=0 and transfer needs hr_full=1, so the
            // set below and the clears in the FSM never fire on the same edge.
            if (accept) begin
                hr_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    Q      <= IDLE_LEVEL;
                    OE_OUT <= 1'b0;
                    if (hr_full) begin
                        sr      <= hr;
                        hr_full <= 1'b0;
                        cnt     <= '0;
                        Q       <= first_bit(hr);
                        OE_OUT  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST_CNT) begin
                        sr  <= shift_next(sr);
                        Q   <= first_bit(shift_next(sr));
                        cnt <= cnt + CNT_W'(1);
                    end else if (hr_full) begin
                        // Next word follows the last bit directly
                        sr      <= hr;
                        hr_full <= 1'b0;
                        cnt     <= '0;
                        Q       <= first_bit(hr);
                    end else begin
                        state   <= IDLE;
                        Q       <= IDLE_LEVEL;
                        OE_OUT  <= 1'b0;
                        TX_DONE <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_o_serializer.sv
// Testbench for o_serializer: two instances (8-bit LSB-first idle-low and
// 4-bit MSB-first idle-high) against a word-schedule reference model.
module tb_o_serializer;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [7:0] d8 = '0;
    logic       v8 = 1'b0;
    logic       rdy8, q8, oe8, tx8;
    logic [3:0] d4 = '0;
    logic       v4 = 1'b0;
    logic       rdy4, q4, oe4, tx4;

    always #5 clk = ~clk;

    o_serializer #(.WIDTH(8), .BIT_ORDER("LSB_FIRST"), .IDLE_LEVEL(1'b0)) dut8 (
        .CLK_IN(clk), .RST(rst_n), .D(d8), .DATA_VALID(v8),
        .DATA_READY(rdy8), .Q(q8), .OE_OUT(oe8), .TX_DONE(tx8)
    );

    o_serializer #(.WIDTH(4), .BIT_ORDER("MSB_FIRST"), .IDLE_LEVEL(1'b1)) dut4 (
        .CLK_IN(clk), .RST(rst_n), .D(d4), .DATA_VALID(v4),
        .DATA_READY(rdy4), .Q(q4), .OE_OUT(oe4), .TX_DONE(tx4)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    int cfg_w   [2] = '{8, 4};
    bit cfg_msb [2] = '{1'b0, 1'b1};
    bit cfg_idle[2] = '{1'b0, 1'b1};

    // Reference model: every accepted word with its accept edge and start edge
    localparam int MAXW = 2048;
    int          wa[2][MAXW];
    int          ws[2][MAXW];
    logic [15:0] wd[2][MAXW];
    int          nw [2] = '{0, 0};
    bit          acc[2] = '{1'b0, 1'b0};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready(input int i, input int e);
        int k;
        if (nw[i] == 0) return 1'b1;
        k = nw[i] - 1;
        return !(wa[i][k] <= e && ws[i][k] > e);
    endfunction

    function automatic logic m_q(input int i, input int e);
        logic r = cfg_idle[i];
        for (int k = (nw[i] > 3 ? nw[i] - 3 : 0); k < nw[i]; k++) begin
            if (ws[i][k] <= e && e < ws[i][k] + cfg_w[i]) begin
                int idx = e - ws[i][k];
                r = cfg_msb[i] ? wd[i][k][cfg_w[i] - 1 - idx] : wd[i][k][idx];
            end
        end
        return r;
    endfunction

    function automatic logic m_oe(input int i, input int e);
        logic r = 1'b0;
        for (int k = (nw[i] > 3 ? nw[i] - 3 : 0); k < nw[i]; k++) begin
            if (ws[i][k] <= e && e < ws[i][k] + cfg_w[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic m_tx(input int i, input int e);
        bit ended = 1'b0;
        bit started = 1'b0;
        for (int k = (nw[i] > 3 ? nw[i] - 3 : 0); k < nw[i]; k++) begin
            if (ws[i][k] + cfg_w[i] == e) ended = 1'b1;
            if (ws[i][k] == e) started = 1'b1;
        end
        return ended && !started;
    endfunction

    function automatic logic [3:0] dut_outs(input int i);
        return (i == 0) ? {q8, oe8, tx8, rdy8} : {q4, oe4, tx4, rdy4};
    endfunction

    // One clock: record model acceptance, clock, then compare every output
    task automatic tick();
        int e = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            bit          v   = (i == 0) ? v8 : v4;
            logic [15:0] dat = (i == 0) ? {8'h00, d8} : {12'h000, d4};
            acc[i] = 1'b0;
            if (rst_n && v && m_ready(i, e - 1) && nw[i] < MAXW) begin
                int s = e + 1;
                if (nw[i] > 0 && ws[i][nw[i] - 1] + cfg_w[i] > s) s = ws[i][nw[i] - 1] + cfg_w[i];
                wa[i][nw[i]] = e;
                ws[i][nw[i]] = s;
                wd[i][nw[i]] = dat;
                nw[i]++;
                acc[i] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc = e;
        for (int i = 0; i < 2; i++) begin
            logic [3:0] o = dut_outs(i);
            check($sformatf("q%0d@%0d", i, e),   {15'h0, o[3]}, {15'h0, m_q(i, e)});
            check($sformatf("oe%0d@%0d", i, e),  {15'h0, o[2]}, {15'h0, m_oe(i, e)});
            check($sformatf("tx%0d@%0d", i, e),  {15'h0, o[1]}, {15'h0, m_tx(i, e)});
            check($sformatf("rdy%0d@%0d", i, e), {15'h0, o[0]}, {15'h0, m_ready(i, e)});
        end
    endtask

    // Assert reset between edges and check the outputs respond without a clock
    task automatic rst_assert();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            logic [3:0] o = dut_outs(i);
            check($sformatf("rst_q%0d", i),   {15'h0, o[3]}, {15'h0, cfg_idle[i]});
            check($sformatf("rst_oe%0d", i),  {15'h0, o[2]}, 16'h0);
            check($sformatf("rst_tx%0d", i),  {15'h0, o[1]}, 16'h0);
            check($sformatf("rst_rdy%0d", i), {15'h0, o[0]}, 16'h1);
            nw[i] = 0;
        end
    endtask

    initial begin
        logic [7:0]  cap8;
        logic [3:0]  cap4;
        logic [15:0] cap16;
        int          oe_drops;
        int          tx_cnt;
        int          ones;
        int          p;

        #1;
        rst_assert();
        tick();
        tick();
        rst_n = 1'b1;

        // Single words: A5 LSB-first on dut8, 1000 MSB-first on dut4
        d8 = 8'hA5; v8 = 1'b1;
        d4 = 4'b1000; v4 = 1'b1;
        tick();
        v8 = 1'b0; v4 = 1'b0;
        d8 = 8'h00; d4 = 4'h0;
        cap8 = '0; cap4 = '0;
        for (int j = 0; j < 8; j++) begin
            tick();
            cap8[j] = q8;
            if (j < 4) cap4[3 - j] = q4;
        end
        check("a5_bits", {8'h00, cap8}, 16'h00A5);
        check("msb_bits", {12'h000, cap4}, 16'h0008);
        tick();
        check("a5_done", {15'h0, tx8}, 16'h1);
        for (int j = 0; j < 3; j++) tick();

        // Back-to-back A5 then 3C with valid held high
        d8 = 8'hA5; v8 = 1'b1;
        tick();
        d8 = 8'h3C;
        cap16 = '0; oe_drops = 0; tx_cnt = 0;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (acc[0]) begin
                v8 = 1'b0;
                d8 = 8'h00;
            end
            cap16[j] = q8;
            oe_drops += (oe8 ? 0 : 1);
            tx_cnt   += (tx8 ? 1 : 0);
        end
        for (int j = 0; j < 3; j++) begin
            tick();
            tx_cnt += (tx8 ? 1 : 0);
        end
        check("b2b_bits", cap16, 16'h3CA5);
        check("b2b_oe_drops", 16'(oe_drops), 16'h0);
        check("b2b_tx_cnt", 16'(tx_cnt), 16'h1);

        // Reset after three bits of FF with 00 queued behind it
        d8 = 8'hFF; v8 = 1'b1;
        tick();
        d8 = 8'h00;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (acc[0]) v8 = 1'b0;
        end
        v8 = 1'b0;
        rst_assert();
        tick();
        tick();
        rst_n = 1'b1;
        ones = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            ones += ((q8 || oe8) ? 1 : 0);
        end
        check("rst_discard", 16'(ones), 16'h0);

        // Randomized traffic with changing D, varying load and occasional resets
        p = 2;
        for (int c = 0; c < 800; c++) begin
            if (c % 40 == 0) p = $urandom_range(1, 4);
            if ($urandom_range(0, 199) == 0) begin
                rst_assert();
                tick();
                tick();
                rst_n = 1'b1;
                v8 = 1'b1; d8 = 8'($urandom);
                v4 = 1'b1; d4 = 4'($urandom);
            end else begin
                v8 = ($urandom_range(0, 3) < p);
                d8 = 8'($urandom);
                v4 = ($urandom_range(0, 3) < p);
                d4 = 4'($urandom);
            end
            tick();
        end
        v8 = 1'b0; v4 = 1'b0;
        for (int j = 0; j < 12; j++) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
